// File: rtl/elevator_call_arbiter.sv
// -----------------------------------------------------------------------------
// elevator_call_arbiter
//
// Request scheduler in front of the elevator car controller. Button presses
// from the hall-up, hall-down and car panels are latched into pending
// registers, which also drive the button lamps. Pending calls are issued one
// at a time, round-robin, over a valid/ready port. Each accepted issue is
// followed by a minimum idle gap. A call is cleared when the car controller
// reports that stop as served.
//
// Source index map: car f -> f, hall-up f -> 8+f, hall-down f -> 16+f.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   hall_up[8]       up-button press pulses (bit 7 ignored)
//   hall_down[8]     down-button press pulses (bit 0 ignored)
//   car_req[8]       car-panel press pulses
//   current_floor[3] car position, used for car-call direction
//   emergency        blocks the start of a new issue
//   served_valid     one-cycle pulse: a stop has been completed
//   served_floor[3]  floor of the completed stop
//   served_dir       direction of the completed stop (1 = up)
//   out_valid        issued call presented (registered)
//   out_ready        car controller accepts the call
//   out_floor[3]     floor of the issued call (registered)
//   out_dir          direction of the issued call, 1 = up (registered)
//   pending_up/down/car[8]  pending-call lamps (registered)
//   queue_empty      no call pending (combinational from pending registers)
// -----------------------------------------------------------------------------
module elevator_call_arbiter #(
  parameter int unsigned NUM_SRC     = 24,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hall_up,
  input  logic [7:0] hall_down,
  input  logic [7:0] car_req,
  input  logic [2:0] current_floor,
  input  logic       emergency,
  input  logic       served_valid,
  input  logic [2:0] served_floor,
  input  logic       served_dir,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_floor,
  output logic       out_dir,
  output logic [7:0] pending_up,
  output logic [7:0] pending_down,
  output logic [7:0] pending_car,
  output logic       queue_empty
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   issued;
  logic [NUM_SRC-1:0]   set_vec;
  logic [NUM_SRC-1:0]   clr_vec;
  logic [NUM_SRC-1:0]   hs_set;
  logic [NUM_SRC-1:0]   eligible;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     next_ptr;
  logic [CNT_W-1:0]     gap_cnt;
  logic [IDX_W:0]       scan_idx;
  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic [2:0]           pick_floor;
  logic                 pick_dir;
  logic                 handshake;

  // Press vector; the top hall-up and bottom hall-down buttons do not exist.
  assign set_vec = {hall_down & 8'hFE, hall_up & 8'h7F, car_req};

  // Served stop clears the car call at that floor and the hall call in the
  // direction the car was travelling.
  always_comb begin
    clr_vec = '0;
    if (served_valid) begin
      clr_vec[{2'b00, served_floor}] = 1'b1;
      if (served_dir) begin
        clr_vec[{2'b01, served_floor}] = 1'b1;
      end else begin
        clr_vec[{2'b10, served_floor}] = 1'b1;
      end
    end
  end

  assign handshake = (state == ISSUE) && out_ready;

  // A handshake only marks the winner issued if its call survived until now;
  // a same-cycle serve (even with a re-press) leaves it unissued.
  always_comb begin
    hs_set = '0;
    if (handshake && pending[winner] && !clr_vec[winner]) begin
      hs_set[winner] = 1'b1;
    end
  end

  // Pending/issued bookkeeping; a press beats a same-cycle serve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      issued  <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      issued  <= (issued & ~clr_vec) | hs_set;
    end
  end

  assign eligible = pending & ~issued;

  // Round-robin scan starting at ptr, wrapping modulo NUM_SRC.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      scan_idx = (IDX_W+1)'(ptr) + (IDX_W+1)'(i);
      if (scan_idx >= (IDX_W+1)'(NUM_SRC)) begin
        scan_idx = scan_idx - (IDX_W+1)'(NUM_SRC);
      end
      if (!found && eligible[scan_idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[IDX_W-1:0];
      end
    end
  end

  // Low three index bits are the floor for every source group. Car calls
  // point up only when the floor is strictly above the car.
  assign pick_floor = pick[2:0];

  always_comb begin
    pick_dir = 1'b0;
    case (pick[4:3])
      2'b00:   pick_dir = (pick[2:0] > current_floor);
      2'b01:   pick_dir = 1'b1;
      default: pick_dir = 1'b0;
    endcase
  end

  assign next_ptr = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);

  // Issue state machine with registered call outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_floor <= '0;
      out_dir   <= 1'b0;
      winner    <= '0;
      ptr       <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!emergency && found) begin
            winner    <= pick;
            out_floor <= pick_floor;
            out_dir   <= pick_dir;
            out_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Call stays presented until accepted, regardless of emergency.
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= next_ptr;
            gap_cnt   <= GAP_LOAD;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pending_car  = pending[7:0];
  assign pending_up   = pending[15:8];
  assign pending_down = pending[23:16];
  assign queue_empty  = ~|pending;

endmodule

// File: tb/tb_elevator_call_arbiter.sv
// -----------------------------------------------------------------------------
// tb_elevator_call_arbiter
//
// Directed bench for elevator_call_arbiter. Expected issues (floor, direction,
// spacing from the previous accepted issue) are queued when stimulus is
// applied; a negedge monitor pops and checks them at every accepted handshake
// and flags any call presented while nothing is expected.
// -----------------------------------------------------------------------------
module tb_elevator_call_arbiter;

  typedef struct packed {
    logic [2:0]  floor;
    logic        dir;
    int unsigned gap;   // cycles since previous handshake, 0 = unchecked
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] hall_up;
  logic [7:0] hall_down;
  logic [7:0] car_req;
  logic [2:0] current_floor;
  logic       emergency;
  logic       served_valid;
  logic [2:0] served_floor;
  logic       served_dir;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_floor;
  logic       out_dir;
  logic [7:0] pending_up;
  logic [7:0] pending_down;
  logic [7:0] pending_car;
  logic       queue_empty;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  int   hs_count;
  int   cyc;
  int   last_hs_cyc;

  elevator_call_arbiter #(.NUM_SRC(24), .HOLD_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .hall_up       (hall_up),
    .hall_down     (hall_down),
    .car_req       (car_req),
    .current_floor (current_floor),
    .emergency     (emergency),
    .served_valid  (served_valid),
    .served_floor  (served_floor),
    .served_dir    (served_dir),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_floor     (out_floor),
    .out_dir       (out_dir),
    .pending_up    (pending_up),
    .pending_down  (pending_down),
    .pending_car   (pending_car),
    .queue_empty   (queue_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_floor", int'(out_floor), -1);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("issue_floor", int'(out_floor), int'(e.floor));
        chk("issue_dir", int'(out_dir), int'(e.dir));
        if (e.gap != 0) chk("issue_spacing", cyc - last_hs_cyc, int'(e.gap));
      end
      if (out_ready) begin
        last_hs_cyc = cyc;
        hs_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int floor, input int dir, input int gap);
    exp_t e;
    e.floor = 3'(floor);
    e.dir   = 1'(dir);
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_hs(input int n);
    int target;
    int budget;
    target = hs_count + n;
    budget = 100;
    while (hs_count < target && budget > 0) begin
      tick();
      budget--;
    end
    if (hs_count < target) chk("handshake_timeout", hs_count, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    int budget;
    n_vec = 0; n_err = 0; hs_count = 0; cyc = 0; last_hs_cyc = 0;
    reset = 1'b1;
    hall_up = '0; hall_down = '0; car_req = '0;
    current_floor = 3'd2; emergency = 1'b0;
    served_valid = 1'b0; served_floor = '0; served_dir = 1'b0;
    out_ready = 1'b0;
    ticks(2);

    // Reset values
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_floor", int'(out_floor), 0);
    chk("rst_out_dir", int'(out_dir), 0);
    chk("rst_lamps", int'({pending_up, pending_down, pending_car}), 0);
    chk("rst_queue_empty", int'(queue_empty), 1);
    reset = 1'b0;

    // Car call floor 5 with car at floor 2, held unaccepted.
    car_req = 8'h20;
    push(5, 1, 0);
    tick();
    car_req = '0;
    chk("car5_lamp", int'(pending_car), 8'h20);
    chk("car5_valid_early", int'(out_valid), 0);
    tick();
    chk("car5_valid", int'(out_valid), 1);
    chk("car5_floor", int'(out_floor), 5);
    chk("car5_dir", int'(out_dir), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_floor", int'(out_floor), 5);
      chk("hold_dir", int'(out_dir), 1);
    end
    out_ready = 1'b1;
    wait_hs(1);
    do_reset();

    // Three simultaneous presses from ptr 0: car 1, hall-up 2, hall-down 6.
    car_req = 8'h02; hall_up = 8'h04; hall_down = 8'h40;
    push(1, 0, 0);
    push(2, 1, 6);
    push(6, 0, 6);
    tick();
    car_req = '0; hall_up = '0; hall_down = '0;
    wait_hs(3);
    // ptr now 23: hall-down 7 (s23) must beat car 0 (s0).
    hall_down = 8'h80; car_req = 8'h01;
    push(7, 0, 0);
    push(0, 0, 6);
    tick();
    hall_down = '0; car_req = '0;
    wait_hs(2);

    // Re-press of an issued hall-up 3 must not re-issue.
    hall_up = 8'h08;
    push(3, 1, 0);
    tick();
    hall_up = '0;
    wait_hs(1);
    hall_up = 8'h08;
    tick();
    hall_up = '0;
    ticks(12);
    chk("repress_no_issue", int'(out_valid), 0);
    chk("repress_lamp_up", int'(pending_up), 8'h0C);
    // Serve and re-press in the same cycle: lamp stays, call re-issues.
    served_valid = 1'b1; served_floor = 3'd3; served_dir = 1'b1;
    hall_up = 8'h08;
    push(3, 1, 0);
    tick();
    served_valid = 1'b0; hall_up = '0;
    chk("serve_press_lamp", int'(pending_up), 8'h0C);
    wait_hs(1);
    // Plain serve of hall-down 6 clears only that lamp.
    served_valid = 1'b1; served_floor = 3'd6; served_dir = 1'b0;
    tick();
    served_valid = 1'b0;
    chk("serve_down6_lamp", int'(pending_down), 8'h80);
    do_reset();

    // Non-existent buttons.
    hall_up = 8'h80; hall_down = 8'h01;
    tick();
    hall_up = '0; hall_down = '0;
    for (int i = 0; i < 4; i++) begin
      chk("ghost_lamps", int'({pending_up, pending_down}), 0);
      chk("ghost_queue_empty", int'(queue_empty), 1);
      tick();
    end
    chk("ghost_no_issue", int'(out_valid), 0);

    // Emergency blocks a new issue but not one already presented.
    emergency = 1'b1; car_req = 8'h10; out_ready = 1'b0;
    tick();
    car_req = '0;
    ticks(8);
    chk("emerg_block", int'(out_valid), 0);
    chk("emerg_lamp", int'(pending_car), 8'h10);
    push(4, 1, 0);
    emergency = 1'b0;
    ticks(2);
    chk("emerg_release_valid", int'(out_valid), 1);
    emergency = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("emerg_hold_valid", int'(out_valid), 1);
      chk("emerg_hold_floor", int'(out_floor), 4);
    end
    out_ready = 1'b1;
    wait_hs(1);
    emergency = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset while a call is presented.
    car_req = 8'h40;
    push(6, 1, 0);
    tick();
    car_req = '0;
    budget = 20;
    while (!out_valid && budget > 0) begin
      tick();
      budget--;
    end
    chk("pre_reset_valid", int'(out_valid), 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_floor", int'(out_floor), 0);
    chk("async_rst_dir", int'(out_dir), 0);
    chk("async_rst_lamps", int'({pending_up, pending_down, pending_car}), 0);
    chk("async_rst_empty", int'(queue_empty), 1);
    exp_q.delete();
    tick();
    reset = 1'b0;
    ticks(4);
    chk("leftover_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
